myo_spi_responder: RTL and testbench

SPI responder that emulates the motor-board end of the myocontrol SPI link, so the FPGA-side SPI master can be exercised in-system without muscle hardware. It sits on the 50 MHz fabric clock behind one ss_n line of a myocontrol port. It receives 16-bit command words from the master and returns a frame of 16-bit status words. Status words come from a register bank written by local logic and are snapshotted at frame start.

---
 rtl/myo_spi_pkg.sv | 19 +
 rtl/spi_sync_edge.sv | 38 +++
 rtl/myo_spi_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_myo_spi_responder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/myo_spi_pkg.sv
// myo_spi_pkg: shared types and constants for the myocontrol SPI responder.
//   WORD_BITS   : SPI word width (16).
//   myo_word_t  : one 16-bit command/status word.
//   myo_idx_t   : 4-bit word/bit index.
//   myo_state_t : responder frame FSM states.
package myo_spi_pkg;

  localparam int unsigned WORD_BITS = 16;

  typedef logic [WORD_BITS-1:0] myo_word_t;
  typedef logic [3:0]           myo_idx_t;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT
  } myo_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: SYNC_STAGES-deep synchronizer followed by one edge-detect
// flop. Rise/fall are single-cycle pulses in the clk domain.
// Ports:
//   clk, reset : fabric clock, async active-high reset
//   din        : asynchronous input pin
//   level      : synchronized level
//   rise, fall : one-cycle pulses on synchronized transitions
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Resetting to 0 keeps ss_n looking "selected" after reset, so the
  // responder waits for a genuine high level before accepting a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/myo_spi_responder.sv
// myo_spi_responder: emulates the motor-board end of a myocontrol SPI link.
// Receives 16-bit command words (CPOL=0, CPHA=1, MSB first) and returns a
// frame of FRAME_WORDS status words snapshotted from a local register bank
// at frame start. Everything runs on clk; sck/mosi/ss_n are oversampled.
// Optional feature macro: MYO_SPI_RESPONDER_CHECKSUM_EN
//   defined   : last transmit word is the XOR of the preceding snapshot words;
//               last received word is checked against the XOR of the
//               preceding received words (checksum_err pulse on mismatch).
//   undefined : all words from the snapshot, checksum_err tied 0.
// Ports:
//   clk, reset            : 50 MHz fabric clock, async active-high reset
//   sck, mosi, ss_n       : SPI pins from the master
//   miso, miso_oe         : responder data and pad output enable
//   status_wr/addr/data   : bank write port (16 x 16)
//   rx_valid/word/index   : received-word strobe, data and frame position
//   frame_done/error      : clean / aborted-or-overlong frame end pulses
//   checksum_err          : checksum mismatch pulse (with frame_done)
//   frame_count           : count of clean frames, wraps
module myo_spi_responder
  import myo_spi_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        mosi,
  input  logic        ss_n,
  output logic        miso,
  output logic        miso_oe,
  input  logic        status_wr,
  input  logic [3:0]  status_addr,
  input  logic [15:0] status_data,
  output logic        rx_valid,
  output logic [15:0] rx_word,
  output logic [3:0]  rx_index,
  output logic        frame_done,
  output logic        frame_error,
  output logic        checksum_err,
  output logic [15:0] frame_count
);

  localparam logic [4:0] FRAME_END = 5'(FRAME_WORDS);
  localparam logic [4:0] LAST_IDX  = 5'(FRAME_WORDS - 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic ss_lvl, ss_rise, ss_fall;
  logic unused_sync;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .reset(reset), .din(sck),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
    .clk(clk), .reset(reset), .din(ss_n),
    .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  assign unused_sync = &{1'b0, sck_lvl, mosi_rise, mosi_fall};

  myo_state_t state_q, state_d;
  logic       start_frame, end_clean, end_abort, do_tx, do_rx;

  myo_word_t  bank [16];
  myo_word_t  snap [FRAME_WORDS];
  myo_word_t  tx_word;
  myo_word_t  rx_new;
  logic [WORD_BITS-2:0] rx_shift;
  myo_idx_t   bit_cnt;
  logic [4:0] word_idx;   // one bit wider than 4 so FRAME_WORDS=16 is reachable
  logic       overrun;    // a full word arrived past the end of the frame

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= WAIT_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    end_clean   = 1'b0;
    end_abort   = 1'b0;
    do_tx       = 1'b0;
    do_rx       = 1'b0;
    unique case (state_q)
      WAIT_IDLE: begin
        if (ss_lvl) state_d = IDLE;
      end
      IDLE: begin
        if (ss_fall) begin
          start_frame = 1'b1;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = IDLE;
          if (bit_cnt == '0 && word_idx == FRAME_END && !overrun) end_clean = 1'b1;
          else                                                    end_abort = 1'b1;
        end else begin
          do_tx = sck_rise;
          do_rx = sck_fall;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 16; i++) bank[i] <= '0;
    end else if (status_wr) begin
      bank[status_addr] <= status_data;
    end
  end

  // ---------------------------------------------------------------- transmit word
`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
  myo_word_t snap_xor;

  always_comb begin
    snap_xor = '0;
    for (int unsigned i = 0; i < FRAME_WORDS - 1; i++) snap_xor = snap_xor ^ snap[i];
  end
`endif

  always_comb begin
    tx_word = '0;
    if (word_idx < FRAME_END) tx_word = snap[word_idx[3:0]];
`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
    if (word_idx == LAST_IDX) tx_word = snap_xor;
`endif
  end

  assign rx_new = {rx_shift, mosi_lvl};

  // ---------------------------------------------------------------- datapath
  // Snapshot reads bank before any same-cycle write lands, so a write in the
  // ss_n-fall action cycle is seen only by the following frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      rx_valid    <= 1'b0;
      rx_word     <= '0;
      rx_index    <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= '0;
      bit_cnt     <= '0;
      word_idx    <= '0;
      overrun     <= 1'b0;
      rx_shift    <= '0;
      for (int unsigned i = 0; i < FRAME_WORDS; i++) snap[i] <= '0;
    end else begin
      rx_valid    <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;

      if (start_frame) begin
        for (int unsigned i = 0; i < FRAME_WORDS; i++) snap[i] <= bank[i];
        bit_cnt  <= '0;
        word_idx <= '0;
        overrun  <= 1'b0;
        miso_oe  <= 1'b1;
        miso     <= 1'b0;
      end

      if (end_clean || end_abort) begin
        miso_oe     <= 1'b0;
        miso        <= 1'b0;
        frame_done  <= end_clean;
        frame_error <= end_abort;
        if (end_clean) frame_count <= frame_count + 1'b1;
      end

      // ~bit_cnt is 15-bit_cnt: MSB first; tx_word is 0 past the frame end.
      if (do_tx) miso <= tx_word[~bit_cnt];

      if (do_rx) begin
        rx_shift <= rx_new[WORD_BITS-2:0];
        bit_cnt  <= bit_cnt + 1'b1;
        if (bit_cnt == 4'hF) begin
          if (word_idx < FRAME_END) begin
            rx_valid <= 1'b1;
            rx_word  <= rx_new;
            rx_index <= word_idx[3:0];
            word_idx <= word_idx + 1'b1;
          end else begin
            overrun  <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------- checksum
`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
  myo_word_t rx_xor;
  logic      chk_bad;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_xor       <= '0;
      chk_bad      <= 1'b0;
      checksum_err <= 1'b0;
    end else begin
      checksum_err <= end_clean & chk_bad;
      if (start_frame) begin
        rx_xor  <= '0;
        chk_bad <= 1'b0;
      end else if (do_rx && bit_cnt == 4'hF && word_idx < FRAME_END) begin
        if (word_idx == LAST_IDX) chk_bad <= (rx_new != rx_xor);
        else                      rx_xor  <= rx_xor ^ rx_new;
      end
    end
  end
`else
  assign checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_myo_spi_responder.sv
// tb_myo_spi_responder: randomized self-checking bench for myo_spi_responder.
// A behavioural master drives frames; expectations come from a frame-level
// model (bank array, snapshot copy, word lists) kept in the bench.
module tb_myo_spi_responder;

  localparam int unsigned FW   = 12;
  localparam int unsigned SS   = 2;
  localparam int unsigned HALF = 5;   // clk cycles per sck half-period (5 MHz)

  logic        clk = 1'b0;
  logic        rst;
  logic        sck, mosi, ss_n;
  logic        miso, miso_oe;
  logic        status_wr;
  logic [3:0]  status_addr;
  logic [15:0] status_data;
  logic        rx_valid;
  logic [15:0] rx_word;
  logic [3:0]  rx_index;
  logic        frame_done, frame_error, checksum_err;
  logic [15:0] frame_count;

  always #10 clk = ~clk;

  myo_spi_responder #(.FRAME_WORDS(FW), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(rst), .sck(sck), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .miso_oe(miso_oe),
    .status_wr(status_wr), .status_addr(status_addr), .status_data(status_data),
    .rx_valid(rx_valid), .rx_word(rx_word), .rx_index(rx_index),
    .frame_done(frame_done), .frame_error(frame_error),
    .checksum_err(checksum_err), .frame_count(frame_count)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // ---------------- monitor (only this process writes these)
  logic [19:0] rx_q[$];
  int unsigned n_done = 0, n_err = 0, n_chk = 0, n_chk_alone = 0;

  always @(negedge clk) begin
    if (rx_valid)     rx_q.push_back({rx_index, rx_word});
    if (frame_done)   n_done++;
    if (frame_error)  n_err++;
    if (checksum_err) n_chk++;
    if (checksum_err && !frame_done) n_chk_alone++;
  end

  // ---------------- reference model
  logic [15:0] bank_m [16];
  logic [15:0] snap_m [FW];
  logic [15:0] m_tx [32];
  logic [15:0] m_rx [32];
  int unsigned fc_m;
  int unsigned q_base, done_base, err_base, chk_base, oe_low;

  function automatic logic [15:0] exp_tx(input int unsigned w);
    logic [15:0] x;
    if (w >= FW) return 16'h0000;
`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
    if (w == FW - 1) begin
      x = '0;
      for (int unsigned i = 0; i < FW - 1; i++) x = x ^ snap_m[i];
      return x;
    end
`endif
    x = snap_m[w];
    return x;
  endfunction

  function automatic int unsigned exp_chk(input int unsigned nbits);
`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
    logic [15:0] x;
    if (nbits != 16 * FW) return 0;
    x = '0;
    for (int unsigned i = 0; i < FW - 1; i++) x = x ^ m_tx[i];
    return (x != m_tx[FW-1]) ? 1 : 0;
`else
    return (nbits == 0) ? 0 : 0;
`endif
  endfunction

  function automatic int unsigned exp_rx_count(input int unsigned nbits);
    return (nbits / 16 < FW) ? nbits / 16 : FW;
  endfunction

  // ---------------- drivers
  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bank_write(input logic [3:0] a, input logic [15:0] d);
    status_wr = 1'b1; status_addr = a; status_data = d;
    wait_clk(1);
    status_wr = 1'b0;
    bank_m[a] = d;
  endtask

  task automatic spi_begin(input bit race, input logic [3:0] ra, input logic [15:0] rd);
    for (int unsigned i = 0; i < FW; i++) snap_m[i] = bank_m[i];
    oe_low = 0;
    ss_n = 1'b0;
    if (race) begin
      // strobe lands in the cycle the synchronized ss_n fall is acted on
      wait_clk(SS);
      status_wr = 1'b1; status_addr = ra; status_data = rd;
      wait_clk(1);
      status_wr = 1'b0;
      bank_m[ra] = rd;
      wait_clk(HALF - SS);
    end else begin
      wait_clk(HALF + 1);
    end
  endtask

  task automatic spi_bits(input int unsigned first, input int unsigned n);
    int unsigned w, k;
    for (int unsigned b = first; b < first + n; b++) begin
      w = b / 16;
      k = 15 - (b % 16);
      sck = 1'b1;
      mosi = m_tx[w][k];
      wait_clk(HALF);
      m_rx[w][k] = miso;
      if (!miso_oe) oe_low++;
      sck = 1'b0;
      wait_clk(HALF);
    end
  endtask

  task automatic spi_end;
    wait_clk(HALF);
    ss_n = 1'b1;
    mosi = 1'b0;
    wait_clk(SS + 4);
  endtask

  task automatic do_frame(input int unsigned nbits, input bit race,
                          input logic [3:0] ra, input logic [15:0] rd);
    q_base = rx_q.size(); done_base = n_done; err_base = n_err; chk_base = n_chk;
    spi_begin(race, ra, rd);
    spi_bits(0, nbits);
    spi_end();
    if (nbits == 16 * FW) fc_m = (fc_m + 1) % 65536;
  endtask

  // ---------------- tests
  task automatic test_reset;
    rst = 1'b1; sck = 1'b0; mosi = 1'b0; ss_n = 1'b1;
    status_wr = 1'b0; status_addr = '0; status_data = '0;
    for (int unsigned i = 0; i < 16; i++) bank_m[i] = '0;
    fc_m = 0;
    wait_clk(3);
    vectors++; if (miso !== 1'b0)         begin miscompares++; $display("FAIL reset.miso got %b want 0", miso); end
    vectors++; if (miso_oe !== 1'b0)      begin miscompares++; $display("FAIL reset.miso_oe got %b want 0", miso_oe); end
    vectors++; if (rx_valid !== 1'b0)     begin miscompares++; $display("FAIL reset.rx_valid got %b want 0", rx_valid); end
    vectors++; if (rx_word !== 16'h0)     begin miscompares++; $display("FAIL reset.rx_word got %h want 0000", rx_word); end
    vectors++; if (rx_index !== 4'h0)     begin miscompares++; $display("FAIL reset.rx_index got %h want 0", rx_index); end
    vectors++; if ({frame_done, frame_error, checksum_err} !== 3'b000)
      begin miscompares++; $display("FAIL reset.pulses got %b want 000", {frame_done, frame_error, checksum_err}); end
    vectors++; if (frame_count !== 16'h0) begin miscompares++; $display("FAIL reset.frame_count got %h want 0000", frame_count); end
    rst = 1'b0;
    wait_clk(SS + 4);
  endtask

  task automatic test_basic;
    for (int unsigned i = 0; i < FW; i++) bank_write(4'(i), 16'h1000 + 16'(i));
    for (int unsigned i = 0; i < 32; i++) m_tx[i] = 16'hA5A5;
    do_frame(16 * FW, 1'b0, 4'h0, 16'h0);
    for (int unsigned w = 0; w < FW; w++) begin
      vectors++; if (m_rx[w] !== exp_tx(w))
        begin miscompares++; $display("FAIL basic.miso_word[%0d] got %h want %h", w, m_rx[w], exp_tx(w)); end
    end
    vectors++; if (rx_q.size() - q_base !== FW)
      begin miscompares++; $display("FAIL basic.rx_count got %0d want %0d", rx_q.size() - q_base, FW); end
    for (int unsigned i = 0; i < FW && q_base + i < rx_q.size(); i++) begin
      vectors++; if (rx_q[q_base+i] !== {4'(i), 16'hA5A5})
        begin miscompares++; $display("FAIL basic.rx[%0d] got %h want %h", i, rx_q[q_base+i], {4'(i), 16'hA5A5}); end
    end
    vectors++; if (n_done - done_base !== 1) begin miscompares++; $display("FAIL basic.frame_done got %0d want 1", n_done - done_base); end
    vectors++; if (n_err - err_base !== 0)   begin miscompares++; $display("FAIL basic.frame_error got %0d want 0", n_err - err_base); end
    vectors++; if (frame_count !== 16'(fc_m)) begin miscompares++; $display("FAIL basic.frame_count got %0d want %0d", frame_count, fc_m); end
    vectors++; if (oe_low !== 0) begin miscompares++; $display("FAIL basic.miso_oe_in_frame got %0d low samples want 0", oe_low); end
    vectors++; if ({miso_oe, miso} !== 2'b00) begin miscompares++; $display("FAIL basic.idle_pins got %b want 00", {miso_oe, miso}); end
  endtask

  task automatic test_abort;
    int unsigned fc_before;
    fc_before = fc_m;
    for (int unsigned i = 0; i < 32; i++) m_tx[i] = 16'($urandom);
    do_frame(3 * 16 + 8, 1'b0, 4'h0, 16'h0);
    vectors++; if (rx_q.size() - q_base !== 3)
      begin miscompares++; $display("FAIL abort.rx_count got %0d want 3", rx_q.size() - q_base); end
    vectors++; if (n_err - err_base !== 1)   begin miscompares++; $display("FAIL abort.frame_error got %0d want 1", n_err - err_base); end
    vectors++; if (n_done - done_base !== 0) begin miscompares++; $display("FAIL abort.frame_done got %0d want 0", n_done - done_base); end
    vectors++; if (frame_count !== 16'(fc_before)) begin miscompares++; $display("FAIL abort.frame_count got %0d want %0d", frame_count, fc_before); end
    vectors++; if (miso_oe !== 1'b0) begin miscompares++; $display("FAIL abort.miso_oe got %b want 0", miso_oe); end
    vectors++; if (m_rx[3][15:8] !== exp_tx(3) >> 8)
      begin miscompares++; $display("FAIL abort.partial_word got %h want %h", m_rx[3][15:8], exp_tx(3) >> 8); end
  endtask

  task automatic test_overlong;
    for (int unsigned i = 0; i < 32; i++) m_tx[i] = 16'($urandom);
    do_frame(16 * (FW + 1), 1'b0, 4'h0, 16'h0);
    vectors++; if (rx_q.size() - q_base !== FW)
      begin miscompares++; $display("FAIL overlong.rx_count got %0d want %0d", rx_q.size() - q_base, FW); end
    vectors++; if (m_rx[FW] !== 16'h0000) begin miscompares++; $display("FAIL overlong.extra_miso got %h want 0000", m_rx[FW]); end
    vectors++; if (n_err - err_base !== 1)   begin miscompares++; $display("FAIL overlong.frame_error got %0d want 1", n_err - err_base); end
    vectors++; if (n_done - done_base !== 0) begin miscompares++; $display("FAIL overlong.frame_done got %0d want 0", n_done - done_base); end
  endtask

  task automatic test_snapshot_race;
    logic [15:0] old0;
    bank_write(4'h0, 16'h1234);
    old0 = bank_m[0];
    for (int unsigned i = 0; i < 32; i++) m_tx[i] = 16'($urandom);
    do_frame(16 * FW, 1'b1, 4'h0, 16'hBEEF);
    vectors++; if (m_rx[0] !== old0) begin miscompares++; $display("FAIL race.word0_old got %h want %h", m_rx[0], old0); end
    do_frame(16 * FW, 1'b0, 4'h0, 16'h0);
    vectors++; if (m_rx[0] !== 16'hBEEF) begin miscompares++; $display("FAIL race.word0_new got %h want beef", m_rx[0]); end
    vectors++; if (frame_count !== 16'(fc_m)) begin miscompares++; $display("FAIL race.frame_count got %0d want %0d", frame_count, fc_m); end
  endtask

  task automatic test_reset_mid_frame;
    for (int unsigned i = 0; i < 32; i++) m_tx[i] = 16'($urandom);
    spi_begin(1'b0, 4'h0, 16'h0);
    spi_bits(0, 20);
    rst = 1'b1;
    wait_clk(2);
    vectors++; if ({miso, miso_oe, rx_valid} !== 3'b000)
      begin miscompares++; $display("FAIL rstmid.pins got %b want 000", {miso, miso_oe, rx_valid}); end
    vectors++; if (frame_count !== 16'h0) begin miscompares++; $display("FAIL rstmid.frame_count got %h want 0000", frame_count); end
    for (int unsigned i = 0; i < 16; i++) bank_m[i] = '0;
    fc_m = 0;
    rst = 1'b0;
    q_base = rx_q.size(); done_base = n_done; err_base = n_err;
    oe_low = 0;
    spi_bits(20, 16 * FW - 20);
    spi_end();
    vectors++; if (rx_q.size() - q_base !== 0) begin miscompares++; $display("FAIL rstmid.rx_count got %0d want 0", rx_q.size() - q_base); end
    vectors++; if ((n_done - done_base) + (n_err - err_base) !== 0)
      begin miscompares++; $display("FAIL rstmid.end_pulses got %0d want 0", (n_done - done_base) + (n_err - err_base)); end
    vectors++; if (oe_low !== 16 * FW - 20) begin miscompares++; $display("FAIL rstmid.miso_oe_low got %0d want %0d", oe_low, 16 * FW - 20); end
    do_frame(16 * FW, 1'b0, 4'h0, 16'h0);
    vectors++; if (n_done - done_base !== 1) begin miscompares++; $display("FAIL rstmid.next_done got %0d want 1", n_done - done_base); end
    vectors++; if (frame_count !== 16'(fc_m)) begin miscompares++; $display("FAIL rstmid.next_count got %0d want %0d", frame_count, fc_m); end
  endtask

  task automatic test_random;
    int unsigned nbits, nrx;
    for (int unsigned iter = 0; iter < 6; iter++) begin
      for (int unsigned j = 0; j < 4; j++) bank_write(4'($urandom), 16'($urandom));
      for (int unsigned i = 0; i < 32; i++) m_tx[i] = 16'($urandom);
      nbits = (iter % 2 == 0) ? 16 * FW : $urandom_range(16, 16 * FW + 30);
      do_frame(nbits, 1'b0, 4'h0, 16'h0);
      nrx = exp_rx_count(nbits);
      for (int unsigned w = 0; w < nbits / 16; w++) begin
        vectors++; if (m_rx[w] !== exp_tx(w))
          begin miscompares++; $display("FAIL rand%0d.miso_word[%0d] got %h want %h", iter, w, m_rx[w], exp_tx(w)); end
      end
      vectors++; if (rx_q.size() - q_base !== nrx)
        begin miscompares++; $display("FAIL rand%0d.rx_count got %0d want %0d", iter, rx_q.size() - q_base, nrx); end
      for (int unsigned i = 0; i < nrx && q_base + i < rx_q.size(); i++) begin
        vectors++; if (rx_q[q_base+i] !== {4'(i), m_tx[i]})
          begin miscompares++; $display("FAIL rand%0d.rx[%0d] got %h want %h", iter, i, rx_q[q_base+i], {4'(i), m_tx[i]}); end
      end
      vectors++; if (n_done - done_base !== ((nbits == 16 * FW) ? 1 : 0))
        begin miscompares++; $display("FAIL rand%0d.frame_done got %0d (nbits %0d)", iter, n_done - done_base, nbits); end
      vectors++; if (n_err - err_base !== ((nbits == 16 * FW) ? 0 : 1))
        begin miscompares++; $display("FAIL rand%0d.frame_error got %0d (nbits %0d)", iter, n_err - err_base, nbits); end
      vectors++; if (n_chk - chk_base !== exp_chk(nbits))
        begin miscompares++; $display("FAIL rand%0d.checksum_err got %0d want %0d", iter, n_chk - chk_base, exp_chk(nbits)); end
      vectors++; if (frame_count !== 16'(fc_m))
        begin miscompares++; $display("FAIL rand%0d.frame_count got %0d want %0d", iter, frame_count, fc_m); end
    end
  endtask

  task automatic test_checksum;
`ifdef MYO_SPI_RESPONDER_CHECKSUM_EN
    logic [15:0] x;
    for (int unsigned i = 0; i < FW - 1; i++) bank_write(4'(i), 16'(i + 1));
    for (int unsigned i = 0; i < 32; i++) m_tx[i] = 16'($urandom);
    x = '0;
    for (int unsigned i = 0; i < FW - 1; i++) x = x ^ m_tx[i];
    m_tx[FW-1] = ~x;
    do_frame(16 * FW, 1'b0, 4'h0, 16'h0);
    vectors++; if (m_rx[FW-1] !== exp_tx(FW - 1))
      begin miscompares++; $display("FAIL chk.tx_word got %h want %h", m_rx[FW-1], exp_tx(FW - 1)); end
    vectors++; if (n_chk - chk_base !== 1) begin miscompares++; $display("FAIL chk.checksum_err got %0d want 1", n_chk - chk_base); end
    vectors++; if (n_done - done_base !== 1) begin miscompares++; $display("FAIL chk.frame_done got %0d want 1", n_done - done_base); end
    vectors++; if (n_chk_alone !== 0) begin miscompares++; $display("FAIL chk.alignment got %0d stray pulses want 0", n_chk_alone); end
`else
    vectors++; if (n_chk !== 0) begin miscompares++; $display("FAIL chk.tied_low got %0d pulses want 0", n_chk); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_overlong();
    test_snapshot_race();
    test_reset_mid_frame();
    test_random();
    test_checksum();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
